// File: rtl/pc_unit_if.sv
// ============================================================================
// Module      : pc_unit_if
// Description : Control/datapath bundle between the control FSM and pc_unit.
//               taken_cnt exists only when TAKEN_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_unit_if #(
  parameter int PC_W   = 10,
  parameter int DISP_W = 8
) ();
  logic              pc_en;
  logic [1:0]        pc_sel;
  logic [3:0]        cond;
  logic [4:0]        flags;
  logic [DISP_W-1:0] disp;
  logic [PC_W-1:0]   rtarget;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   link;
  logic              taken;
`ifdef TAKEN_COUNT_EN
  logic [15:0]       taken_cnt;
`endif

  modport master (
    output pc_en, pc_sel, cond, flags, disp, rtarget,
`ifdef TAKEN_COUNT_EN
    input  taken_cnt,
`endif
    input  pc, link, taken
  );

  modport slave (
    input  pc_en, pc_sel, cond, flags, disp, rtarget,
`ifdef TAKEN_COUNT_EN
    output taken_cnt,
`endif
    output pc, link, taken
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter with increment, conditional relative branch
//               and conditional absolute jump. Optional macro TAKEN_COUNT_EN
//               adds a saturating count of taken branches/jumps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int          PC_W     = 10,
  parameter int          DISP_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  wire        clk,
  input  wire        rst_n,
  pc_unit_if.slave   bus
);

  localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
  localparam logic [1:0]      c_sel_incr = 2'b00;
  localparam logic [1:0]      c_sel_rel  = 2'b01;
  localparam logic [1:0]      c_sel_abs  = 2'b10;

  logic [PC_W-1:0] r_pc;
  logic            r_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_disp_ext;
  logic [PC_W-1:0] w_pc_next;
  logic            w_cond_ok;
  logic            w_take;
  logic            w_n, w_z, w_f, w_l, w_c;

  assign {w_n, w_z, w_f, w_l, w_c} = bus.flags;
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_disp_ext = PC_W'(signed'(bus.disp));

  always_comb begin
    w_cond_ok = 1'b0;
    case (bus.cond)
      4'h0: w_cond_ok = w_z;
      4'h1: w_cond_ok = ~w_z;
      4'h2: w_cond_ok = w_c;
      4'h3: w_cond_ok = ~w_c;
      4'h4: w_cond_ok = w_l;
      4'h5: w_cond_ok = ~w_l;
      4'h6: w_cond_ok = w_n;
      4'h7: w_cond_ok = ~w_n;
      4'h8: w_cond_ok = w_f;
      4'h9: w_cond_ok = ~w_f;
      4'hA: w_cond_ok = ~w_l & ~w_z;
      4'hB: w_cond_ok = w_l | w_z;
      4'hC: w_cond_ok = ~w_n & ~w_z;
      4'hD: w_cond_ok = w_n | w_z;
      4'hE: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_take    = 1'b0;
    w_pc_next = r_pc;
    case (bus.pc_sel)
      c_sel_incr: w_pc_next = w_pc_inc;
      c_sel_rel: begin
        w_take    = w_cond_ok;
        w_pc_next = w_cond_ok ? (r_pc + w_disp_ext) : w_pc_inc;
      end
      c_sel_abs: begin
        w_take    = w_cond_ok;
        w_pc_next = w_cond_ok ? bus.rtarget : w_pc_inc;
      end
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= c_reset_pc;
      r_taken <= 1'b0;
    end else begin
      // taken is a one-cycle pulse; any edge without a taken update clears it
      r_taken <= bus.pc_en & w_take;
      if (bus.pc_en)
        r_pc <= w_pc_next;
    end
  end

`ifdef TAKEN_COUNT_EN
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_taken_cnt <= 16'h0000;
    else if (bus.pc_en && w_take && (r_taken_cnt != 16'hFFFF))
      r_taken_cnt <= r_taken_cnt + 16'h0001;
  end

  assign bus.taken_cnt = r_taken_cnt;
`endif

  assign bus.pc    = r_pc;
  assign bus.link  = w_pc_inc;
  assign bus.taken = r_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Scoreboard bench for pc_unit; directed vectors, expected
//               results queued by the driver and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  localparam int PC_W   = 10;
  localparam int DISP_W = 8;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb_q[$];

  pc_unit_if #(.PC_W(PC_W), .DISP_W(DISP_W)) bus ();

  pc_unit #(.PC_W(PC_W), .DISP_W(DISP_W), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven at the falling edge; expectation is for the
  // state right after the following rising edge.
  task automatic step(input logic en, input logic [1:0] sel, input logic [3:0] cnd,
                      input logic [4:0] flg, input logic [DISP_W-1:0] dsp,
                      input logic [PC_W-1:0] rt, input logic [PC_W-1:0] exp_pc,
                      input logic exp_tk);
    exp_t e;
    @(negedge clk);
    bus.pc_en   = en;
    bus.pc_sel  = sel;
    bus.cond    = cnd;
    bus.flags   = flg;
    bus.disp    = dsp;
    bus.rtarget = rt;
    e.pc    = exp_pc;
    e.taken = exp_tk;
    sb_q.push_back(e);
  endtask

  task automatic jump_to(input logic [PC_W-1:0] t);
    step(1'b1, 2'b10, 4'hE, 5'b0, 8'h00, t, t, 1'b1);
  endtask

  task automatic idle(input logic [PC_W-1:0] hold_pc);
    step(1'b0, 2'b10, 4'hE, 5'b0, 8'h00, 10'h2AA, hold_pc, 1'b0);
  endtask

  // Monitor: compares whenever an expectation is outstanding
  initial begin
    exp_t e;
    logic [PC_W-1:0] exp_link;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_link = e.pc + 10'd1;
        chk("pc",    32'(bus.pc),    32'(e.pc));
        chk("taken", 32'(bus.taken), 32'(e.taken));
        chk("link",  32'(bus.link),  32'(exp_link));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.pc_en = 1'b0; bus.pc_sel = 2'b00; bus.cond = 4'h0;
    bus.flags = 5'b0; bus.disp = '0; bus.rtarget = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc",    32'(bus.pc),    32'h0);
    chk("rst_taken", 32'(bus.taken), 32'h0);
    chk("rst_link",  32'(bus.link),  32'h1);
`ifdef TAKEN_COUNT_EN
    chk("rst_cnt", 32'(bus.taken_cnt), 32'h0);
`endif
    rst_n = 1'b1;

    // Increment, then hold while a would-be-taken jump is presented
    step(1, 2'b00, 4'h0, 5'b0, 8'h00, 10'h000, 10'd1, 0);
    step(1, 2'b00, 4'h0, 5'b0, 8'h00, 10'h000, 10'd2, 0);
    step(1, 2'b00, 4'h0, 5'b0, 8'h00, 10'h000, 10'd3, 0);
    idle(10'd3);
    idle(10'd3);
    jump_to(10'd5);
    idle(10'd5);

    // Relative branch on EQ: taken backwards, then not taken
    step(1, 2'b01, 4'h0, 5'b01000, 8'hFD, 10'h000, 10'd2, 1);
    jump_to(10'd5);
    step(1, 2'b01, 4'h0, 5'b00000, 8'hFD, 10'h000, 10'd6, 0);
    // disp=0 taken leaves pc unchanged but flags taken
    step(1, 2'b01, 4'hE, 5'b00000, 8'h00, 10'h000, 10'd6, 1);
    // LO with L=Z=0 taken, +127
    step(1, 2'b01, 4'hA, 5'b00000, 8'h7F, 10'h000, 10'h085, 1);
    // HS with L=Z=0 not taken
    step(1, 2'b01, 4'hB, 5'b00000, 8'h7F, 10'h000, 10'h086, 0);
    // GE with N=1 absolute jump
    step(1, 2'b10, 4'hD, 5'b10000, 8'h00, 10'h3F0, 10'h3F0, 1);
    // HI with L=1, -128
    step(1, 2'b01, 4'h4, 5'b00010, 8'h80, 10'h000, 10'h370, 1);
    // LT with Z=1 not taken
    step(1, 2'b10, 4'hC, 5'b01000, 8'h00, 10'h100, 10'h371, 0);

    // Absolute jump unconditional and never
    jump_to(10'h010);
    step(1, 2'b10, 4'hE, 5'b00000, 8'h00, 10'h200, 10'h200, 1);
    jump_to(10'h010);
    step(1, 2'b10, 4'hF, 5'b11111, 8'h00, 10'h200, 10'h011, 0);

    // Wrap at top of address space
    jump_to(10'h3FF);
    @(negedge clk);
    bus.pc_en = 1'b0;
    chk("link_wrap", 32'(bus.link), 32'h0);
    step(1, 2'b00, 4'h0, 5'b0, 8'h00, 10'h000, 10'h000, 0);
    step(1, 2'b11, 4'hE, 5'b0, 8'h05, 10'h155, 10'h000, 0);
    jump_to(10'h3FE);
    step(1, 2'b01, 4'hE, 5'b0, 8'h05, 10'h000, 10'h003, 1);

    // Asynchronous reset between edges
    jump_to(10'h123);
    @(negedge clk);
    bus.pc_en = 1'b0;
    chk("pre_rst_pc", 32'(bus.pc), 32'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc",    32'(bus.pc),    32'h0);
    chk("async_taken", 32'(bus.taken), 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_pc", 32'(bus.pc), 32'h0);
    rst_n = 1'b1;
    step(1, 2'b00, 4'h0, 5'b0, 8'h00, 10'h000, 10'd1, 0);

`ifdef TAKEN_COUNT_EN
    chk("cnt_after_rst", 32'(bus.taken_cnt), 32'h0);
    step(1, 2'b10, 4'hE, 5'b00000, 8'h00, 10'h050, 10'h050, 1);
    step(1, 2'b01, 4'hE, 5'b00000, 8'h02, 10'h000, 10'h052, 1);
    step(1, 2'b01, 4'h0, 5'b01000, 8'h01, 10'h000, 10'h053, 1);
    step(1, 2'b01, 4'hF, 5'b11111, 8'h01, 10'h000, 10'h054, 0);
    step(1, 2'b10, 4'h1, 5'b01000, 8'h00, 10'h300, 10'h055, 0);
    idle(10'h055);
    chk("cnt3", 32'(bus.taken_cnt), 32'h3);
    force dut.r_taken_cnt = 16'hFFFF;
    #1 release dut.r_taken_cnt;
    jump_to(10'h060);
    idle(10'h060);
    chk("cnt_sat", 32'(bus.taken_cnt), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 32'(bus.taken_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    bus.pc_en = 1'b0;
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
